change_dispenser: RTL and testbench

- Coin-output end of the vending path. The coin acceptor FSM collects Q/D/N; this block pays change back out as Q/D/N.
- Takes a change amount in nickel units and ejects coins one at a time using greedy selection (largest coin first) from its own coin inventory.
- Each coin is handshaked with the coin-ejector mechanism.
- Reports done, or a shortfall when the inventory cannot cover the amount.

---
 rtl/vend_pkg.sv | 36 +++
 rtl/coin_inventory.sv | 56 +++++
 rtl/change_dispenser.sv | 141 ++++++++++++++
 tb/tb_change_dispenser.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values in nickel units,
// coin one-hot bundle and change dispenser state encoding.
`timescale 1ns/1ps
package vend_pkg;

  localparam logic [2:0] COIN_Q = 3'd5;
  localparam logic [2:0] COIN_D = 3'd2;
  localparam logic [2:0] COIN_N = 3'd1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_EJECT  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  typedef struct packed {
    logic q;
    logic d;
    logic n;
  } coin_sel_t;

  function automatic logic [2:0] coin_value(
    input coin_sel_t c
  );
    logic [2:0] v;
    v = 3'd0;
    unique case (1'b1)
      c.q:     v = COIN_Q;
      c.d:     v = COIN_D;
      c.n:     v = COIN_N;
      default: v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-type coin counters: saturating bulk load,
// single-coin decrement on a one-hot select.
`timescale 1ns/1ps
module coin_inventory
  import vend_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_q,
  input  logic [CNT_W-1:0] load_d,
  input  logic [CNT_W-1:0] load_n,
  input  coin_sel_t        dec,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt,
  output logic             q_nz,
  output logic             d_nz,
  output logic             n_nz
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (reset) begin
      q_cnt <= '0;
      d_cnt <= '0;
      n_cnt <= '0;
    end else if (load) begin
      q_cnt <= sat_add(q_cnt, load_q);
      d_cnt <= sat_add(d_cnt, load_d);
      n_cnt <= sat_add(n_cnt, load_n);
    end else begin
      // Caller only decrements a non-empty type.
      if (dec.q) q_cnt <= q_cnt - ONE;
      if (dec.d) d_cnt <= d_cnt - ONE;
      if (dec.n) n_cnt <= n_cnt - ONE;
    end
  end

  assign q_nz = |q_cnt;
  assign d_nz = |d_cnt;
  assign n_nz = |n_cnt;

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout: picks Q/D/N from inventory,
// handshakes each coin with the ejector, reports done/short.
`timescale 1ns/1ps
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W = 4,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             load,
  input  logic [CNT_W-1:0] load_q,
  input  logic [CNT_W-1:0] load_d,
  input  logic [CNT_W-1:0] load_n,
  output logic             eject_Q,
  output logic             eject_D,
  output logic             eject_N,
  input  logic             eject_ack,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt
);

  localparam logic [AMT_W-1:0] V_Q = AMT_W'(COIN_Q);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(COIN_D);
  localparam logic [AMT_W-1:0] V_N = AMT_W'(COIN_N);

  logic [2:0]       state;
  logic [2:0]       nxt;
  coin_sel_t        ej;
  coin_sel_t        pick;
  coin_sel_t        dec;
  logic             q_nz;
  logic             d_nz;
  logic             n_nz;
  logic             inv_load;
  logic             paid;
  logic [AMT_W-1:0] rem_nxt;

  assign inv_load = load && (state == ST_IDLE);
  assign paid     = (state == ST_EJECT) && eject_ack;
  assign dec      = paid ? ej : '0;
  assign rem_nxt  = remaining - AMT_W'(coin_value(ej));

  coin_inventory #(
    .CNT_W (CNT_W)
  ) u_inv (
    .CLK    (CLK),
    .reset  (reset),
    .load   (inv_load),
    .load_q (load_q),
    .load_d (load_d),
    .load_n (load_n),
    .dec    (dec),
    .q_cnt  (q_cnt),
    .d_cnt  (d_cnt),
    .n_cnt  (n_cnt),
    .q_nz   (q_nz),
    .d_nz   (d_nz),
    .n_nz   (n_nz)
  );

  always_comb begin
    pick = '0;
    priority case (1'b1)
      (remaining >= V_Q) && q_nz: pick.q = 1'b1;
      (remaining >= V_D) && d_nz: pick.d = 1'b1;
      (remaining >= V_N) && n_nz: pick.n = 1'b1;
      default:                    pick   = '0;
    endcase
  end

  always_comb begin
    nxt = ST_IDLE;
    unique case (state)
      ST_IDLE: begin
        if (!start)
          nxt = ST_IDLE;
        else if (change_amt == '0)
          nxt = ST_DONE;
        else
          nxt = ST_SELECT;
      end
      ST_SELECT:
        nxt = (|pick) ? ST_EJECT : ST_FAULT;
      ST_EJECT: begin
        if (!eject_ack)
          nxt = ST_EJECT;
        else if (rem_nxt == '0)
          nxt = ST_DONE;
        else
          nxt = ST_SELECT;
      end
      ST_DONE:  nxt = ST_IDLE;
      ST_FAULT: nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Status pulses trail the DONE/FAULT state by one cycle,
  // and busy covers that trailing cycle too.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      ej        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      remaining <= '0;
    end else begin
      state <= nxt;
      busy  <= (nxt != ST_IDLE) || (state != ST_IDLE);
      done  <= (state == ST_DONE);
      short <= (state == ST_FAULT);
      unique case (state)
        ST_IDLE:
          if (start) remaining <= change_amt;
        ST_SELECT:
          ej <= pick;
        ST_EJECT:
          if (eject_ack) begin
            ej        <= '0;
            remaining <= rem_nxt;
          end
        default: ;
      endcase
    end
  end

  assign eject_Q = ej.q;
  assign eject_D = ej.d;
  assign eject_N = ej.n;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed-vector bench for change_dispenser:
// payout order, shortfall, lockout, reset and saturation.
`timescale 1ns/1ps
module tb_change_dispenser;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] change_amt;
  logic       load;
  logic [5:0] load_q;
  logic [5:0] load_d;
  logic [5:0] load_n;
  logic       eject_Q;
  logic       eject_D;
  logic       eject_N;
  logic       eject_ack;
  logic       busy;
  logic       done;
  logic       short;
  logic [3:0] remaining;
  logic [5:0] q_cnt;
  logic [5:0] d_cnt;
  logic [5:0] n_cnt;

  int passed = 0;
  int total  = 0;

  logic [2:0] ejq[$];
  logic       got_done;
  logic       got_short;
  logic       timed_out;
  logic       multi_hot;

  always #5 CLK = ~CLK;

  change_dispenser #(
    .AMT_W (4),
    .CNT_W (6)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .change_amt (change_amt),
    .load       (load),
    .load_q     (load_q),
    .load_d     (load_d),
    .load_n     (load_n),
    .eject_Q    (eject_Q),
    .eject_D    (eject_D),
    .eject_N    (eject_N),
    .eject_ack  (eject_ack),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .remaining  (remaining),
    .q_cnt      (q_cnt),
    .d_cnt      (d_cnt),
    .n_cnt      (n_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    load = 1'b0;
    eject_ack = 1'b0;
    change_amt = '0;
    load_q = '0;
    load_d = '0;
    load_n = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(
    input logic [5:0] q,
    input logic [5:0] d,
    input logic [5:0] n
  );
    load = 1'b1;
    load_q = q;
    load_d = d;
    load_n = n;
    tick();
    load = 1'b0;
    load_q = '0;
    load_d = '0;
    load_n = '0;
  endtask

  task automatic run_payout(input logic [3:0] amt);
    ejq.delete();
    got_done = 1'b0;
    got_short = 1'b0;
    timed_out = 1'b1;
    multi_hot = 1'b0;
    change_amt = amt;
    start = 1'b1;
    tick();
    start = 1'b0;
    change_amt = '0;
    for (int i = 0; i < 100; i++) begin
      tick();
      eject_ack = 1'b0;
      if ($countones({eject_Q, eject_D, eject_N}) > 1)
        multi_hot = 1'b1;
      if (done) begin
        got_done = 1'b1;
        timed_out = 1'b0;
        break;
      end
      if (short) begin
        got_short = 1'b1;
        timed_out = 1'b0;
        break;
      end
      if (eject_Q | eject_D | eject_N) begin
        ejq.push_back({eject_Q, eject_D, eject_N});
        eject_ack = 1'b1;
      end
    end
    eject_ack = 1'b0;
  endtask

  function automatic logic [2:0] ej_at(input int k);
    return (ejq.size() > k) ? ejq[k] : 3'b000;
  endfunction

  task automatic test_reset();
    do_reset();
    total++;
    if ({eject_Q, eject_D, eject_N} !== 3'b000) begin
      $display("FAIL reset_eject got %b want 000",
               {eject_Q, eject_D, eject_N});
    end else passed++;
    total++;
    if ({busy, done, short} !== 3'b000) begin
      $display("FAIL reset_flags got %b want 000",
               {busy, done, short});
    end else passed++;
    total++;
    if (remaining !== 4'd0) begin
      $display("FAIL reset_rem got %0d want 0", remaining);
    end else passed++;
    total++;
    if ({q_cnt, d_cnt, n_cnt} !== 18'd0) begin
      $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0",
               q_cnt, d_cnt, n_cnt);
    end else passed++;
  endtask

  task automatic test_basic_mix();
    do_reset();
    do_load(6'd2, 6'd2, 6'd2);
    total++;
    if ({q_cnt, d_cnt, n_cnt} !== {6'd2, 6'd2, 6'd2}) begin
      $display("FAIL mix_load got %0d/%0d/%0d want 2/2/2",
               q_cnt, d_cnt, n_cnt);
    end else passed++;
    run_payout(4'd8);
    total++;
    if (!got_done || timed_out) begin
      $display("FAIL mix_done got done=%b to=%b want 1/0",
               got_done, timed_out);
    end else passed++;
    total++;
    if (ejq.size() !== 3) begin
      $display("FAIL mix_count got %0d want 3", ejq.size());
    end else passed++;
    total++;
    if ({ej_at(0), ej_at(1), ej_at(2)} !== 9'b100_010_001)
    begin
      $display("FAIL mix_order got %b %b %b want 100 010 001",
               ej_at(0), ej_at(1), ej_at(2));
    end else passed++;
    total++;
    if (multi_hot !== 1'b0) begin
      $display("FAIL mix_onehot got %b want 0", multi_hot);
    end else passed++;
    total++;
    if ({q_cnt, d_cnt, n_cnt} !== {6'd1, 6'd1, 6'd1}) begin
      $display("FAIL mix_cnt got %0d/%0d/%0d want 1/1/1",
               q_cnt, d_cnt, n_cnt);
    end else passed++;
    total++;
    if (remaining !== 4'd0) begin
      $display("FAIL mix_rem got %0d want 0", remaining);
    end else passed++;
  endtask

  task automatic test_zero_amount();
    logic any_ej;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    do_reset();
    change_amt = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c1 = {busy, done};
    any_ej = eject_Q | eject_D | eject_N;
    tick();
    c2 = {busy, done};
    any_ej = any_ej | eject_Q | eject_D | eject_N;
    tick();
    c3 = {busy, done};
    any_ej = any_ej | eject_Q | eject_D | eject_N;
    total++;
    if ({c1, c2, c3} !== 6'b10_11_00) begin
      $display("FAIL zero_timing got %b want 101100",
               {c1, c2, c3});
    end else passed++;
    total++;
    if (any_ej !== 1'b0) begin
      $display("FAIL zero_eject got %b want 0", any_ej);
    end else passed++;
  endtask

  task automatic test_fallback_short();
    do_reset();
    do_load(6'd0, 6'd0, 6'd4);
    run_payout(4'd3);
    total++;
    if (!got_done || ejq.size() !== 3) begin
      $display("FAIL fb_done got done=%b n=%0d want 1/3",
               got_done, ejq.size());
    end else passed++;
    total++;
    if ({ej_at(0), ej_at(1), ej_at(2)} !== 9'b001_001_001)
    begin
      $display("FAIL fb_order got %b %b %b want 001 x3",
               ej_at(0), ej_at(1), ej_at(2));
    end else passed++;
    total++;
    if (n_cnt !== 6'd1) begin
      $display("FAIL fb_ncnt got %0d want 1", n_cnt);
    end else passed++;
    tick();
    run_payout(4'd6);
    total++;
    if (!got_short || got_done) begin
      $display("FAIL sf_short got short=%b done=%b want 1/0",
               got_short, got_done);
    end else passed++;
    total++;
    if (ejq.size() !== 1 || ej_at(0) !== 3'b001) begin
      $display("FAIL sf_eject got n=%0d %b want 1 001",
               ejq.size(), ej_at(0));
    end else passed++;
    total++;
    if (remaining !== 4'd5 || n_cnt !== 6'd0) begin
      $display("FAIL sf_state got rem=%0d n=%0d want 5/0",
               remaining, n_cnt);
    end else passed++;
    tick();
    tick();
    total++;
    if (remaining !== 4'd5) begin
      $display("FAIL sf_hold got %0d want 5", remaining);
    end else passed++;
  endtask

  task automatic test_greedy_short();
    do_reset();
    do_load(6'd1, 6'd3, 6'd0);
    run_payout(4'd6);
    total++;
    if (!got_short || ejq.size() !== 1 ||
        ej_at(0) !== 3'b100) begin
      $display("FAIL gs_seq got short=%b n=%0d %b want 1 1 100",
               got_short, ejq.size(), ej_at(0));
    end else passed++;
    total++;
    if (remaining !== 4'd1) begin
      $display("FAIL gs_rem got %0d want 1", remaining);
    end else passed++;
    total++;
    if (d_cnt !== 6'd3 || q_cnt !== 6'd0) begin
      $display("FAIL gs_cnt got q=%0d d=%0d want 0/3",
               q_cnt, d_cnt);
    end else passed++;
  endtask

  task automatic test_slow_ack();
    logic seen;
    logic held_ok;
    do_reset();
    do_load(6'd1, 6'd0, 6'd0);
    change_amt = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eject_Q) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      $display("FAIL slow_wait got no eject_Q want eject_Q");
    end else passed++;
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 2);
      change_amt = 4'd3;
      load = (i == 5);
      load_q = 6'd5;
      load_d = 6'd5;
      tick();
      if (!eject_Q || q_cnt !== 6'd1 || !busy)
        held_ok = 1'b0;
    end
    start = 1'b0;
    load = 1'b0;
    load_q = '0;
    load_d = '0;
    change_amt = '0;
    total++;
    if (held_ok !== 1'b1) begin
      $display("FAIL slow_hold got %b want 1", held_ok);
    end else passed++;
    eject_ack = 1'b1;
    tick();
    eject_ack = 1'b0;
    total++;
    if ({eject_Q, q_cnt, d_cnt, remaining} !==
        {1'b0, 6'd0, 6'd0, 4'd0}) begin
      $display("FAIL slow_ack got ej=%b q=%0d d=%0d r=%0d want 0/0/0/0",
               eject_Q, q_cnt, d_cnt, remaining);
    end else passed++;
    tick();
    total++;
    if (done !== 1'b1) begin
      $display("FAIL slow_done got %b want 1", done);
    end else passed++;
    tick();
    total++;
    if ({busy, done, eject_Q, eject_D, eject_N} !== 5'b0) begin
      $display("FAIL slow_idle got %b want 00000",
               {busy, done, eject_Q, eject_D, eject_N});
    end else passed++;
  endtask

  task automatic test_reset_saturation();
    logic seen;
    do_reset();
    do_load(6'd0, 6'd1, 6'd0);
    change_amt = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eject_D) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || d_cnt !== 6'd1) begin
      $display("FAIL rst_pre got seen=%b d=%0d want 1/1",
               seen, d_cnt);
    end else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({eject_Q, eject_D, eject_N, busy} !== 4'b0) begin
      $display("FAIL rst_mid got %b want 0000",
               {eject_Q, eject_D, eject_N, busy});
    end else passed++;
    total++;
    if ({q_cnt, d_cnt, n_cnt, remaining} !== 22'd0) begin
      $display("FAIL rst_cnt got %0d/%0d/%0d r=%0d want zeros",
               q_cnt, d_cnt, n_cnt, remaining);
    end else passed++;
    do_load(6'd0, 6'd0, 6'd40);
    total++;
    if (n_cnt !== 6'd40) begin
      $display("FAIL sat_first got %0d want 40", n_cnt);
    end else passed++;
    do_load(6'd0, 6'd0, 6'd40);
    total++;
    if (n_cnt !== 6'd63) begin
      $display("FAIL sat_second got %0d want 63", n_cnt);
    end else passed++;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    load = 1'b0;
    eject_ack = 1'b0;
    change_amt = '0;
    load_q = '0;
    load_d = '0;
    load_n = '0;
    test_reset();
    test_basic_mix();
    test_zero_amount();
    test_fallback_short();
    test_greedy_short();
    test_slow_ack();
    test_reset_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
